fast_keypoint_collector: RTL and testbench

FAST_KEYPOINT_COLLECTOR -- requirements
Module: fast_keypoint_collector

---
 rtl/fast_keypoint_collector.sv | 166 ++++++++++++++++
 tb/tb_fast_keypoint_collector.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_keypoint_collector.sv
// Collects NMS-marked FAST keypoints from a raster pixel stream into a first-word-fall-through
// FIFO as {type, y, x}, with border rejection, per-frame counting and overflow tracking.
module fast_keypoint_collector #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned BORDER     = 3,
  parameter int unsigned X_W        = 11,
  parameter int unsigned Y_W        = 10,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_image_vs,
  input  logic                   i_image_hs,
  input  logic                   i_image_en,
  input  logic [7:0]             i_image_data,
  output logic                   o_kp_valid,
  input  logic                   i_kp_ready,
  output logic [2+Y_W+X_W-1:0]   o_kp_data,
  output logic                   o_frame_done,
  output logic [CNT_W-1:0]       o_frame_kp_count,
  output logic                   o_overflow
);

  localparam int unsigned KP_W = 2 + Y_W + X_W;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);

  localparam logic [X_W-1:0]   X_MAX   = '1;
  localparam logic [Y_W-1:0]   Y_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [X_W-1:0]   X_LO    = X_W'(BORDER);
  localparam logic [X_W-1:0]   X_HI    = X_W'(IMG_WIDTH - BORDER);
  localparam logic [Y_W-1:0]   Y_LO    = Y_W'(BORDER);
  localparam logic [Y_W-1:0]   Y_HI    = Y_W'(IMG_HEIGHT - BORDER);

  typedef enum logic {StIdle, StFrame} state_e;

  state_e            state_q, state_d;
  logic              vs_q, hs_q;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              cap_valid_q, cap_valid_d;
  logic [KP_W-1:0]   cap_data_q, cap_data_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [KP_W-1:0]   mem_q [FIFO_DEPTH];

  logic vs_rise, vs_fall, hs_fall;
  logic in_frame, frame_start, frame_end;
  logic in_border, candidate;
  logic fifo_empty, fifo_full;
  logic push, drop, pop;
  logic unused_data;

  assign unused_data = ^i_image_data[7:2];

  assign vs_rise     = i_image_vs & ~vs_q;
  assign vs_fall     = ~i_image_vs & vs_q;
  assign hs_fall     = ~i_image_hs & hs_q;
  assign in_frame    = (state_q == StFrame);
  assign frame_start = vs_rise & (state_q == StIdle);
  assign frame_end   = vs_fall & in_frame;

  assign in_border = (x_q >= X_LO) && (x_q < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI);
  assign candidate = in_frame & i_image_en & (|i_image_data[1:0]) & in_border;

  // Extra MSB on the pointers separates full (MSBs differ) from empty (equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = cap_valid_q & ~fifo_full;
  assign drop       = cap_valid_q & fifo_full;
  assign pop        = ~fifo_empty & i_kp_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (vs_rise) state_d = StFrame;
      StFrame: if (vs_fall) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (frame_start) begin
      x_d = '0;
      y_d = '0;
    end else if (hs_fall) begin
      x_d = '0;
      if (in_frame && (y_q != Y_MAX)) y_d = y_q + 1'b1;
    end else if (in_frame && i_image_en && (x_q != X_MAX)) begin
      x_d = x_q + 1'b1;
    end
  end

  always_comb begin
    cap_valid_d = candidate;
    cap_data_d  = {i_image_data[1:0], y_q, x_q};
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  always_comb begin
    cnt_d       = cnt_q;
    ovf_d       = ovf_q | drop;
    frame_cnt_d = frame_cnt_q;
    done_d      = frame_end;
    if (push && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
    if (frame_start) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end
    // A write landing in the frame-end cycle still belongs to the finished frame.
    if (frame_end) frame_cnt_d = cnt_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      vs_q        <= 1'b1;
      hs_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= i_image_vs;
      hs_q        <= i_image_hs;
      x_q         <= x_d;
      y_q         <= y_d;
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= cap_data_q;
  end

  assign o_kp_valid       = ~fifo_empty;
  assign o_kp_data        = mem_q[rd_ptr_q[AW-1:0]];
  assign o_frame_done     = done_q;
  assign o_frame_kp_count = frame_cnt_q;
  assign o_overflow       = ovf_q;

endmodule

// File: tb/tb_fast_keypoint_collector.sv
// Randomized scoreboard bench for fast_keypoint_collector: a queue-level reference model tracks
// the expected FIFO contents and frame status; a negedge monitor compares every cycle.
module tb_fast_keypoint_collector;

  localparam int W = 640, H = 480, B = 3, XW = 11, YW = 10, DEPTH = 64, CW = 16;
  localparam int KW = 2 + YW + XW;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_image_vs = 1'b0, i_image_hs = 1'b0, i_image_en = 1'b0;
  logic [7:0]    i_image_data = 8'h00;
  logic          i_kp_ready = 1'b0;
  logic          o_kp_valid;
  logic [KW-1:0] o_kp_data;
  logic          o_frame_done;
  logic [CW-1:0] o_frame_kp_count;
  logic          o_overflow;

  int checks = 0, errors = 0;

  fast_keypoint_collector #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER(B), .X_W(XW), .Y_W(YW),
    .FIFO_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_image_vs(i_image_vs), .i_image_hs(i_image_hs),
    .i_image_en(i_image_en), .i_image_data(i_image_data), .o_kp_valid(o_kp_valid),
    .i_kp_ready(i_kp_ready), .o_kp_data(o_kp_data), .o_frame_done(o_frame_done),
    .o_frame_kp_count(o_frame_kp_count), .o_overflow(o_overflow)
  );

  initial forever #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit inside_border(input int x, input int y);
    return (x >= B) && (x < W - B) && (y >= B) && (y < H - B);
  endfunction

  // Reference model state (expected values visible after each clock edge).
  logic [KW-1:0] exp_fifo[$];
  bit            m_prev_vs = 1'b1, m_in_frame = 1'b0, m_pend_v = 1'b0;
  logic [KW-1:0] m_pend = '0;
  int            m_count = 0;
  logic          exp_done = 1'b0, exp_ovf = 1'b0;
  logic [CW-1:0] exp_fkc = '0;
  int            cyc = 0;
  int            cur_x = 0, cur_y = 0;

  initial forever begin
    bit full_pre, rise, fall;
    @(posedge i_clk or negedge i_rst_n);
    if (!i_rst_n) begin
      m_prev_vs = 1'b1; m_in_frame = 1'b0; m_pend_v = 1'b0; m_count = 0;
      exp_done = 1'b0; exp_ovf = 1'b0; exp_fkc = '0;
      exp_fifo.delete();
    end else begin
      cyc++;
      full_pre = (exp_fifo.size() == DEPTH);
      rise     = i_image_vs && !m_prev_vs;
      fall     = !i_image_vs && m_prev_vs;
      exp_done = 1'b0;
      if (exp_fifo.size() != 0 && i_kp_ready) void'(exp_fifo.pop_front());
      if (m_pend_v) begin
        if (full_pre) exp_ovf = 1'b1;
        else begin
          exp_fifo.push_back(m_pend);
          if (m_count < 65535) m_count++;
        end
      end
      m_pend_v = m_in_frame && i_image_en && (i_image_data[1:0] != 2'b00) &&
                 inside_border(cur_x, cur_y);
      m_pend   = {i_image_data[1:0], YW'(cur_y), XW'(cur_x)};
      if (rise && !m_in_frame) begin
        m_in_frame = 1'b1; m_count = 0; exp_ovf = 1'b0;
      end else if (fall && m_in_frame) begin
        m_in_frame = 1'b0; exp_done = 1'b1; exp_fkc = CW'(m_count);
      end
      m_prev_vs = i_image_vs;
    end
  end

  // Monitor: compares DUT against the model and logs what was actually handed out.
  int            n_pops = 0, n_done = 0;
  logic [CW-1:0] last_fkc = '0;
  logic [KW-1:0] pop_log[$];
  bit            prev_valid = 1'b0;
  int            valid_rise_cyc = -1;

  initial forever begin
    @(negedge i_clk);
    check("kp_valid", 32'(o_kp_valid), 32'(exp_fifo.size() != 0));
    if (exp_fifo.size() != 0) check("kp_data", 32'(o_kp_data), 32'(exp_fifo[0]));
    check("frame_done", 32'(o_frame_done), 32'(exp_done));
    check("frame_kp_count", 32'(o_frame_kp_count), 32'(exp_fkc));
    check("overflow", 32'(o_overflow), 32'(exp_ovf));
    if (o_kp_valid && i_kp_ready) begin n_pops++; pop_log.push_back(o_kp_data); end
    if (o_frame_done) begin n_done++; last_fkc = o_frame_kp_count; end
    if (o_kp_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = o_kp_valid;
  end

  // Stimulus helpers
  logic [7:0] pix_data [1024];
  bit         pix_rdy  [1024];
  bit         use_rdy = 1'b0, rand_rdy = 1'b0;
  int         last_kp_cyc = 0;

  initial forever begin
    @(posedge i_clk); #1;
    if (rand_rdy) i_kp_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic fill_bg(input int n);
    for (int i = 0; i < n; i++) pix_data[i] = 8'($urandom) & 8'hFC;
  endtask

  task automatic set_kp(input int x, input logic [1:0] t);
    pix_data[x] = (8'($urandom) & 8'hFC) | {6'd0, t};
  endtask

  task automatic send_line(input int npix, input bit gaps);
    i_image_hs = 1'b1;
    tick();
    for (int i = 0; i < npix; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin i_image_en = 1'b0; tick(); end
      i_image_en   = 1'b1;
      i_image_data = pix_data[i];
      cur_x        = i;
      if (use_rdy) i_kp_ready = pix_rdy[i];
      if (pix_data[i][1:0] != 2'b00) last_kp_cyc = cyc;
      tick();
    end
    i_image_en = 1'b0; i_image_data = 8'h00; i_image_hs = 1'b0;
    tick(); tick();
    cur_y++;
  endtask

  task automatic start_frame();
    cur_y = 0; cur_x = 0;
    i_image_vs = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic end_frame();
    i_image_vs = 1'b0;
    repeat (4) tick();
  endtask

  task automatic drain(input int limit);
    int k = 0;
    i_kp_ready = 1'b1;
    while (o_kp_valid && k < limit) begin tick(); k++; end
    check("drain_bound", 32'(k < limit), 32'd1);
    tick(); tick();
  endtask

  initial begin
    int p0, d0;
    #2 i_rst_n = 1'b0;
    #20 i_rst_n = 1'b1;
    tick();
    check("rst_kp_valid", 32'(o_kp_valid), 32'd0);
    check("rst_frame_done", 32'(o_frame_done), 32'd0);
    check("rst_frame_kp_count", 32'(o_frame_kp_count), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);

    // Single keypoint at x=10, y=20
    i_kp_ready = 1'b1;
    p0 = n_pops; d0 = n_done;
    start_frame();
    for (int y = 0; y < 25; y++) begin
      fill_bg(16);
      if (y == 20) set_kp(10, 2'b01);
      send_line(16, 1'b1);
    end
    end_frame();
    check("single_pops", 32'(n_pops - p0), 32'd1);
    check("single_data", 32'(pop_log[$]), 32'({2'b01, 10'd20, 11'd10}));
    check("single_latency", 32'(valid_rise_cyc - last_kp_cyc), 32'd2);
    check("single_done", 32'(n_done - d0), 32'd1);
    check("single_count", 32'(last_fkc), 32'd1);

    // Border rejection: only (3,3) survives
    p0 = n_pops;
    start_frame();
    for (int y = 0; y < 478; y++) begin
      fill_bg(640);
      if (y == 10) begin set_kp(2, 2'b10); set_kp(637, 2'b11); end
      if (y == 2 || y == 477) set_kp(5, 2'b01);
      if (y == 3) set_kp(3, 2'b10);
      send_line((y == 10) ? 640 : 8, 1'b0);
    end
    end_frame();
    check("border_pops", 32'(n_pops - p0), 32'd1);
    check("border_xy", 32'(pop_log[$][KW-3:0]), 32'({10'd3, 11'd3}));
    check("border_count", 32'(last_fkc), 32'd1);

    // Overflow: 70 consecutive candidates with the consumer stalled
    i_kp_ready = 1'b0;
    start_frame();
    for (int y = 0; y < 7; y++) begin
      fill_bg(80);
      if (y == 5) for (int x = 3; x < 73; x++) set_kp(x, 2'($urandom_range(1, 3)));
      send_line(80, 1'b0);
    end
    end_frame();
    check("ovf_flag", 32'(o_overflow), 32'd1);
    check("ovf_count", 32'(last_fkc), 32'd64);
    p0 = pop_log.size();
    drain(300);
    check("ovf_drain_pops", 32'(pop_log.size() - p0), 32'd64);
    for (int k = 0; k < 64 && p0 + k < pop_log.size(); k++)
      check("ovf_drain_x", 32'(pop_log[p0 + k][XW-1:0]), 32'(3 + k));

    // Full FIFO with a pop in the same cycle as a write attempt
    i_kp_ready = 1'b0;
    start_frame();
    for (int y = 0; y < 7; y++) begin
      fill_bg(80);
      for (int i = 0; i < 80; i++) pix_rdy[i] = (i == 68);
      if (y == 5) for (int x = 3; x < 68; x++) set_kp(x, 2'($urandom_range(1, 3)));
      use_rdy = (y == 5);
      send_line(80, 1'b0);
      use_rdy = 1'b0;
    end
    end_frame();
    check("fullpop_ovf", 32'(o_overflow), 32'd1);
    check("fullpop_count", 32'(last_fkc), 32'd64);
    p0 = pop_log.size();
    drain(300);
    check("fullpop_drain_pops", 32'(pop_log.size() - p0), 32'd63);
    if (pop_log.size() > p0) check("fullpop_head_x", 32'(pop_log[p0][XW-1:0]), 32'd4);

    // Back-to-back frames: 5 keypoints, then none
    i_kp_ready = 1'b1;
    start_frame();
    check("b2b_ovf_cleared", 32'(o_overflow), 32'd0);
    for (int y = 0; y < 12; y++) begin
      fill_bg(16);
      if (y >= 4 && y <= 8) set_kp($urandom_range(3, 12), 2'($urandom_range(1, 3)));
      send_line(16, 1'b1);
    end
    end_frame();
    check("b2b_count_a", 32'(last_fkc), 32'd5);
    d0 = n_done;
    start_frame();
    for (int y = 0; y < 12; y++) begin fill_bg(16); send_line(16, 1'b1); end
    end_frame();
    check("b2b_count_b", 32'(last_fkc), 32'd0);
    check("b2b_done_b", 32'(n_done - d0), 32'd1);

    // Reset in the middle of a frame: ignored until the next vs rise
    start_frame();
    for (int y = 0; y < 6; y++) begin
      fill_bg(16);
      if (y == 4) set_kp(6, 2'b10);
      send_line(16, 1'b1);
    end
    i_rst_n = 1'b0;
    #3 i_rst_n = 1'b1;
    tick();
    p0 = n_pops; d0 = n_done;
    for (int y = 6; y < 12; y++) begin
      fill_bg(16);
      set_kp(5, 2'b01);
      send_line(16, 1'b1);
    end
    end_frame();
    check("midrst_pops", 32'(n_pops - p0), 32'd0);
    check("midrst_done", 32'(n_done - d0), 32'd0);
    start_frame();
    for (int y = 0; y < 8; y++) begin
      fill_bg(16);
      if (y == 4 || y == 5) set_kp(7, 2'b11);
      send_line(16, 1'b1);
    end
    end_frame();
    check("midrst_next_pops", 32'(n_pops - p0), 32'd2);
    check("midrst_next_done", 32'(n_done - d0), 32'd1);
    check("midrst_next_count", 32'(last_fkc), 32'd2);

    // Randomized frames with a randomly stalling consumer
    rand_rdy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      start_frame();
      for (int y = 0; y < 10; y++) begin
        fill_bg(30);
        for (int x = 0; x < 30; x++)
          if ($urandom_range(0, 3) == 0) set_kp(x, 2'($urandom_range(1, 3)));
        send_line(30, 1'b1);
      end
      end_frame();
    end
    rand_rdy = 1'b0;
    tick();
    drain(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
